sram_port_arb: RTL and testbench

//  Two-requester controller for the external asynchronous SRAM (19-bit word address, 64-bit data).
//  The write port is fed by the 32->64 packing stream; the read port serves the consumer.

---
 rtl/sram_port_arb_pkg.sv | 28 ++
 rtl/sram_port_arb_rr.sv | 52 +++++
 rtl/sram_port_arb.sv | 160 ++++++++++++++++
 tb/tb_sram_port_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: default widths, FSM state
// encoding, wait-counter width and the counter preload helper.
package sram_port_arb_pkg;

   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 64;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_SETUP  = 3'd1,
      ST_WR_STROBE = 3'd2,
      ST_WR_HOLD   = 3'd3,
      ST_RD_STROBE = 3'd4,
      ST_RD_TURN   = 3'd5
   } state_t;

   typedef enum logic {
      PRI_WR = 1'b0,
      PRI_RD = 1'b1
   } pri_t;

   // Strobe phases count down to zero, so a phase of N cycles preloads N-1.
   function automatic logic [CNT_W-1:0] wait_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_port_arb_rr.sv
// Two-way round-robin grant between the write and read ports. Grants are
// combinational and only issued while the controller is idle; the priority
// flag moves to the other port after every grant.
module sram_port_arb_rr
   import sram_port_arb_pkg::*;
(
   input  logic CLK,
   input  logic RSTn,
   input  logic en_i,
   input  logic wr_req_i,
   input  logic rd_req_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);

   pri_t pri_q;
   pri_t pri_d;
   logic gnt_wr;
   logic gnt_rd;

   // Grant the lone requester, or the priority holder when both request
   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      pri_d  = pri_q;
      if (en_i) begin
         if (wr_req_i && (!rd_req_i || (pri_q == PRI_WR))) begin
            gnt_wr = 1'b1;
         end else if (rd_req_i) begin
            gnt_rd = 1'b1;
         end
         if (gnt_wr) begin
            pri_d = PRI_RD;
         end else if (gnt_rd) begin
            pri_d = PRI_WR;
         end
      end
   end

   assign gnt_wr_o = gnt_wr;
   assign gnt_rd_o = gnt_rd;

   // Priority flag; the write port wins the first contended grant after reset
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         pri_q <= PRI_WR;
      end else begin
         pri_q <= pri_d;
      end
   end

endmodule

// File: rtl/sram_port_arb.sv
// Controller for an external asynchronous SRAM shared by a write port and a
// read port. Sequences CEn/WEn/OEn with programmable strobe lengths, drives
// the data-bus enable, and always returns through IDLE so a read is followed
// by at least one turnaround cycle before the bus can be driven again.
module sram_port_arb
   import sram_port_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int WR_WAIT = 2,
   parameter int RD_WAIT = 2
)(
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [DATA_W-1:0] SRAM_DQ_O,
   input  logic [DATA_W-1:0] SRAM_DQ_I,
   output logic              SRAM_DQ_OE,
   output logic              SRAM_CEn,
   output logic              SRAM_WEn,
   output logic              SRAM_OEn
);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] dq_o_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              wr_ack_q;
   logic              rd_ack_q;
   logic              rd_valid_q;
   logic              busy_q;
   logic              cen_q;
   logic              wen_q;
   logic              oen_q;
   logic              dq_oe_q;
   logic              gnt_wr;
   logic              gnt_rd;

   sram_port_arb_rr u_rr (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .en_i     (state_q == ST_IDLE),
      .wr_req_i (wr_req),
      .rd_req_i (rd_req),
      .gnt_wr_o (gnt_wr),
      .gnt_rd_o (gnt_rd)
   );

   // Access sequencer: every pin and handshake output is a register here
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         dq_o_q     <= '0;
         rd_data_q  <= '0;
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         oen_q      <= 1'b1;
         dq_oe_q    <= 1'b0;
      end else begin
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_wr) begin
                  state_q  <= ST_WR_SETUP;
                  addr_q   <= wr_addr;
                  dq_o_q   <= wr_data;
                  cen_q    <= 1'b0;
                  wen_q    <= 1'b1;
                  dq_oe_q  <= 1'b1;
                  wr_ack_q <= 1'b1;
                  busy_q   <= 1'b1;
               end else if (gnt_rd) begin
                  state_q  <= ST_RD_STROBE;
                  addr_q   <= rd_addr;
                  cen_q    <= 1'b0;
                  oen_q    <= 1'b0;
                  dq_oe_q  <= 1'b0;
                  rd_ack_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= wait_load(RD_WAIT);
               end
            end
            ST_WR_SETUP: begin
               state_q <= ST_WR_STROBE;
               wen_q   <= 1'b0;
               cnt_q   <= wait_load(WR_WAIT);
            end
            ST_WR_STROBE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_WR_HOLD;
                  wen_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               state_q <= ST_IDLE;
               cen_q   <= 1'b1;
               dq_oe_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            ST_RD_STROBE: begin
               if (cnt_q == '0) begin
                  state_q    <= ST_RD_TURN;
                  rd_data_q  <= SRAM_DQ_I;
                  cen_q      <= 1'b1;
                  oen_q      <= 1'b1;
                  rd_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RD_TURN: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cen_q   <= 1'b1;
               wen_q   <= 1'b1;
               oen_q   <= 1'b1;
               dq_oe_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ack     = wr_ack_q;
   assign rd_ack     = rd_ack_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign busy       = busy_q;
   assign SRAM_ADDR  = addr_q;
   assign SRAM_DQ_O  = dq_o_q;
   assign SRAM_DQ_OE = dq_oe_q;
   assign SRAM_CEn   = cen_q;
   assign SRAM_WEn   = wen_q;
   assign SRAM_OEn   = oen_q;

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb. Instance 0 uses WR_WAIT=2/RD_WAIT=2 for directed
// tests; instance 1 uses WR_WAIT=15/RD_WAIT=1 for mixed random traffic.
// Drivers push expected writes/reads into scoreboard FIFOs at ack time; a
// negedge monitor pops and compares when strobes end or rd_valid pulses.
module tb_sram_port_arb;

   localparam int AW = 19;
   localparam int DW = 64;

   logic CLK = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic          rstn [2];
   logic          wr_req [2];
   logic          rd_req [2];
   logic          wr_ack [2];
   logic          rd_ack [2];
   logic          rd_valid [2];
   logic          busy [2];
   logic          cen [2];
   logic          wen [2];
   logic          oen [2];
   logic          dq_oe [2];
   logic [AW-1:0] wr_addr [2];
   logic [AW-1:0] rd_addr [2];
   logic [AW-1:0] sram_addr [2];
   logic [DW-1:0] wr_data [2];
   logic [DW-1:0] rd_data [2];
   logic [DW-1:0] dq_o [2];
   logic [DW-1:0] dq_i [2];

   // SRAM model (indexed by low 6 address bits) and reference contents
   logic [DW-1:0] sram [2][64];
   logic [DW-1:0] model [2][64];
   logic          sram_clr;

   // Scoreboard FIFOs
   logic [AW-1:0] wexp_a [2][256];
   logic [DW-1:0] wexp_d [2][256];
   int            wexp_wp [2];
   int            wexp_rp [2];
   logic [AW-1:0] rexp_a [2][256];
   logic [DW-1:0] rexp_d [2][256];
   int            rexp_wp [2];
   int            rexp_rp [2];

   // Monitor state
   int   wen_run [2];
   logic prev_wen [2];
   int   rd_ack_cyc [2];
   logic idle_next [2];
   int   viol [2];
   int   wr_acks [2];
   int   rd_acks [2];
   logic glog [64];
   int   gl_n = 0;

   sram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(2), .RD_WAIT(2)) u_dut0 (
      .CLK(CLK), .RSTn(rstn[0]),
      .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
      .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]),
      .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]),
      .SRAM_ADDR(sram_addr[0]), .SRAM_DQ_O(dq_o[0]), .SRAM_DQ_I(dq_i[0]),
      .SRAM_DQ_OE(dq_oe[0]), .SRAM_CEn(cen[0]), .SRAM_WEn(wen[0]), .SRAM_OEn(oen[0])
   );

   sram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(15), .RD_WAIT(1)) u_dut1 (
      .CLK(CLK), .RSTn(rstn[1]),
      .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
      .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]),
      .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]),
      .SRAM_ADDR(sram_addr[1]), .SRAM_DQ_O(dq_o[1]), .SRAM_DQ_I(dq_i[1]),
      .SRAM_DQ_OE(dq_oe[1]), .SRAM_CEn(cen[1]), .SRAM_WEn(wen[1]), .SRAM_OEn(oen[1])
   );

   initial forever #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic int wrw(input int k);
      return (k == 0) ? 2 : 15;
   endfunction

   function automatic int rdw(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   // SRAM array: writes while CEn and WEn are low, reads while CEn and OEn are low
   always @(posedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (sram_clr) begin
            for (int i = 0; i < 64; i++) sram[k][i] <= '0;
         end else if (rstn[k] && !cen[k] && !wen[k]) begin
            sram[k][sram_addr[k][5:0]] <= dq_o[k];
         end
      end
   end

   assign dq_i[0] = (!cen[0] && !oen[0]) ? sram[0][sram_addr[0][5:0]] : '0;
   assign dq_i[1] = (!cen[1] && !oen[1]) ? sram[1][sram_addr[1][5:0]] : '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_step(input int k);
      if (dq_oe[k] && !oen[k]) viol[k]++;
      if (!rstn[k]) begin
         prev_wen[k]  = 1'b1;
         wen_run[k]   = 0;
         idle_next[k] = 1'b0;
         wexp_rp[k]   = wexp_wp[k];
         rexp_rp[k]   = rexp_wp[k];
      end else begin
         if (wr_ack[k]) begin
            wr_acks[k]++;
            if (k == 0 && gl_n < 64) begin glog[gl_n] = 1'b0; gl_n++; end
         end
         if (rd_ack[k]) begin
            rd_acks[k]++;
            rd_ack_cyc[k] = cyc;
            if (k == 0 && gl_n < 64) begin glog[gl_n] = 1'b1; gl_n++; end
         end
         if (idle_next[k]) begin
            chk("turn_then_idle_busy", busy[k], 0);
            idle_next[k] = 1'b0;
         end
         if (rd_valid[k]) begin
            chk("rd_latency", cyc - rd_ack_cyc[k], rdw(k));
            chk("rd_expected_pending", rexp_wp[k] != rexp_rp[k], 1);
            if (rexp_wp[k] != rexp_rp[k]) begin
               chk("rd_data", rd_data[k], rexp_d[k][rexp_rp[k] & 255]);
               chk("rd_addr", sram_addr[k], rexp_a[k][rexp_rp[k] & 255]);
               rexp_rp[k]++;
            end
            chk("rd_turn_pins_cen_oen_dqoe", {cen[k], oen[k], dq_oe[k]}, 3'b110);
            idle_next[k] = 1'b1;
         end
         if (!wen[k]) begin
            wen_run[k]++;
         end else if (!prev_wen[k]) begin
            chk("wen_low_cycles", wen_run[k], wrw(k));
            chk("wr_expected_pending", wexp_wp[k] != wexp_rp[k], 1);
            if (wexp_wp[k] != wexp_rp[k]) begin
               chk("wr_addr_pins", sram_addr[k], wexp_a[k][wexp_rp[k] & 255]);
               chk("wr_data_pins", dq_o[k], wexp_d[k][wexp_rp[k] & 255]);
               wexp_rp[k]++;
            end
            chk("wr_hold_pins_cen_dqoe", {cen[k], dq_oe[k]}, 2'b01);
            wen_run[k] = 0;
         end
         prev_wen[k] = wen[k];
      end
   endtask

   // Monitor: samples both instances on the falling edge
   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) mon_step(k);
   end

   task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      wr_addr[k] = a;
      wr_data[k] = d;
      wr_req[k]  = 1'b1;
      do begin @(negedge CLK); n++; end while (!wr_ack[k] && n < 64);
      chk("wr_ack_seen", wr_ack[k], 1);
      if (wr_ack[k]) begin
         wexp_a[k][wexp_wp[k] & 255] = a;
         wexp_d[k][wexp_wp[k] & 255] = d;
         wexp_wp[k]++;
         model[k][a[5:0]] = d;
      end
      wr_req[k]  = 1'b0;
      wr_addr[k] = ~a;
      wr_data[k] = ~d;
   endtask

   task automatic do_read(input int k, input logic [AW-1:0] a);
      int n;
      n = 0;
      rd_addr[k] = a;
      rd_req[k]  = 1'b1;
      do begin @(negedge CLK); n++; end while (!rd_ack[k] && n < 64);
      chk("rd_ack_seen", rd_ack[k], 1);
      if (rd_ack[k]) begin
         rexp_a[k][rexp_wp[k] & 255] = a;
         rexp_d[k][rexp_wp[k] & 255] = model[k][a[5:0]];
         rexp_wp[k]++;
      end
      rd_req[k]  = 1'b0;
      rd_addr[k] = ~a;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin @(negedge CLK); n++; end while (busy[k] && n < 64);
      chk("idle_reached", busy[k], 0);
   endtask

   task automatic check_reset(input int k);
      chk("rst_pins_cen_wen_oen_dqoe", {cen[k], wen[k], oen[k], dq_oe[k]}, 4'b1110);
      chk("rst_sram_addr", sram_addr[k], 0);
      chk("rst_sram_dq_o", dq_o[k], 0);
      chk("rst_rd_data", rd_data[k], 0);
      chk("rst_handshakes_busy", {wr_ack[k], rd_ack[k], rd_valid[k], busy[k]}, 4'b0000);
   endtask

   initial begin
      int a1;
      sram_clr = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rstn[k] = 1'b0; wr_req[k] = 1'b0; rd_req[k] = 1'b0;
         wr_addr[k] = '0; rd_addr[k] = '0; wr_data[k] = '0;
         wexp_wp[k] = 0; wexp_rp[k] = 0; rexp_wp[k] = 0; rexp_rp[k] = 0;
         wen_run[k] = 0; prev_wen[k] = 1'b1; rd_ack_cyc[k] = 0; idle_next[k] = 1'b0;
         viol[k] = 0; wr_acks[k] = 0; rd_acks[k] = 0;
         for (int i = 0; i < 64; i++) model[k][i] = '0;
      end
      repeat (3) @(negedge CLK);
      check_reset(0);
      check_reset(1);
      sram_clr = 1'b0;
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      @(negedge CLK);

      // single write, exactly one ack and two WEn-low cycles
      a1 = wr_acks[0];
      do_write(0, 19'h00010, 64'h0123456789ABCDEF);
      wait_idle(0);
      chk("t1_wr_ack_pulses", wr_acks[0] - a1, 1);

      // read back the word just written
      do_read(0, 19'h00010);
      wait_idle(0);
      chk("t2_rd_data", rd_data[0], 64'h0123456789ABCDEF);

      // read followed immediately by a write request
      do_read(0, 19'h00010);
      do_write(0, 19'h00011, 64'hFEDC_BA98_7654_3210);
      wait_idle(0);
      do_read(0, 19'h00011);
      wait_idle(0);
      chk("t4_rd_data", rd_data[0], 64'hFEDC_BA98_7654_3210);

      // both ports requesting from reset: grants alternate W,R,W,R
      @(negedge CLK);
      rstn[0] = 1'b0;
      repeat (2) @(negedge CLK);
      gl_n = 0;
      rstn[0] = 1'b1;
      fork
         begin
            do_write(0, 19'h00020, 64'hAAAA_5555_0000_0001);
            do_write(0, 19'h00021, 64'hAAAA_5555_0000_0002);
         end
         begin
            do_read(0, 19'h00020);
            do_read(0, 19'h00021);
         end
      join
      wait_idle(0);
      chk("t3_grant_count", gl_n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_grant_%0d_is_rd", i), glog[i], i % 2);
      chk("t3_last_rd_data", rd_data[0], 64'hAAAA_5555_0000_0002);

      // reset asserted during the write strobe
      begin
         int n;
         n = 0;
         wr_addr[0] = 19'h00030;
         wr_data[0] = 64'h1111_2222_3333_4444;
         wr_req[0]  = 1'b1;
         do begin @(negedge CLK); n++; end while (!wr_ack[0] && n < 64);
         chk("t5_wr_ack_seen", wr_ack[0], 1);
         wr_req[0] = 1'b0;
         n = 0;
         while (wen[0] && n < 64) begin @(negedge CLK); n++; end
         chk("t5_in_strobe_wen", wen[0], 0);
         rstn[0] = 1'b0;
         @(negedge CLK);
         chk("t5_pins_wen_cen_dqoe", {wen[0], cen[0], dq_oe[0]}, 3'b110);
         chk("t5_busy", busy[0], 0);
         @(negedge CLK);
         rstn[0] = 1'b1;
         repeat (2) @(negedge CLK);
         chk("t5_post_reset_wen_busy", {wen[0], busy[0]}, 2'b10);
      end

      // mixed random traffic on the long-write / short-read instance
      fork
         for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            do_write(1, AW'($urandom), {$urandom, $urandom});
         end
         for (int j = 0; j < 100; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            do_read(1, AW'($urandom));
         end
      join
      wait_idle(1);
      repeat (2) @(negedge CLK);
      begin
         int mism;
         mism = 0;
         for (int i = 0; i < 64; i++) if (sram[1][i] !== model[1][i]) mism++;
         chk("t6_sram_contents_mismatches", mism, 0);
      end
      chk("t6_wr_acks", wr_acks[1], 100);
      chk("t6_rd_acks", rd_acks[1], 100);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("dqoe_with_oen_low_%0d", k), viol[k], 0);
         chk($sformatf("wr_fifo_drained_%0d", k), wexp_wp[k] - wexp_rp[k], 0);
         chk($sformatf("rd_fifo_drained_%0d", k), rexp_wp[k] - rexp_rp[k], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
